wb_commit_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory-IO stage.
- Retires each instruction: issues the byte-strobed register-file write and commits MTC0/MFC0 accesses to the CP0 register set it owns (Status, Cause, EPC, BadVAddr, Count, Compare).
- Takes precise exceptions and ERET, then broadcasts the flush and redirect to all earlier stages.
- Reports a pending-interrupt flag upstream so decode can tag the next instruction.

---
 rtl/wb_commit_stage.sv | 189 ++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: retires instructions, owns the CP0 register set,
// takes precise exceptions and ERET, and broadcasts flush/redirect upstream.
module wb_commit_stage #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        wb_allow_in,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rf_addr,
  input  logic        in_rf_we,
  input  logic [3:0]  in_rf_strobe,
  input  logic [4:0]  in_cp0_addr,
  input  logic [2:0]  in_cp0_sel,
  input  logic        in_mfc0,
  input  logic        in_mtc0,
  input  logic        in_exc_valid,
  input  logic [4:0]  in_exc_code,
  input  logic        in_bd,
  input  logic        in_eret,
  input  logic        in_addr_fault,
  input  logic [31:0] in_badvaddr,
  input  logic [5:0]  hw_int,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        int_pending,
  output logic        wb_fwd_valid,
  output logic [4:0]  wb_fwd_addr,
  output logic [31:0] wb_fwd_data,
  output logic [31:0] debug_pc
);

  localparam int unsigned TICK_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COUNT_DIV - 1);

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  logic        wb_valid;
  logic [31:0] pc_q, result_q, badvaddr_q;
  logic [4:0]  rf_addr_q, cp0_addr_q, code_q;
  logic [3:0]  strobe_q;
  logic [2:0]  cp0_sel_q;
  logic        rf_we_q, mfc0_q, mtc0_q, exc_q, bd_q, eret_q, af_q;

  logic [7:0]        im;
  logic              exl, ie;
  logic              cause_bd, ti;
  logic [1:0]        ip_sw;
  logic [5:0]        hw_q;
  logic [4:0]        exc_code;
  logic [31:0]       epc, badvaddr, count, compare;
  logic [TICK_W-1:0] tick;

  logic        retire, take_exc, take_eret, do_mtc0;
  logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  logic [31:0] status_val, cause_val, cp0_rdata;

  // Pipeline latch: wb_valid tracks in_valid, payload only moves on a valid transfer.
  always_ff @(posedge clock) begin
    if (reset) wb_valid <= 1'b0;
    else       wb_valid <= in_valid;
    if (in_valid) begin
      pc_q       <= in_pc;
      result_q   <= in_result;
      rf_addr_q  <= in_rf_addr;
      rf_we_q    <= in_rf_we;
      strobe_q   <= in_rf_strobe;
      cp0_addr_q <= in_cp0_addr;
      cp0_sel_q  <= in_cp0_sel;
      mfc0_q     <= in_mfc0;
      mtc0_q     <= in_mtc0;
      exc_q      <= in_exc_valid;
      code_q     <= in_exc_code;
      bd_q       <= in_bd;
      eret_q     <= in_eret;
      af_q       <= in_addr_fault;
      badvaddr_q <= in_badvaddr;
    end
  end

  // Commit decode; reset suppresses any side effect of an in-flight instruction.
  always_comb begin
    retire     = wb_valid & ~reset;
    take_exc   = retire & exc_q;
    take_eret  = retire & ~exc_q & eret_q;
    do_mtc0    = retire & ~exc_q & ~eret_q & mtc0_q;
    wr_status  = do_mtc0 && cp0_sel_q == 3'd0 && cp0_addr_q == CP0_STATUS;
    wr_cause   = do_mtc0 && cp0_sel_q == 3'd0 && cp0_addr_q == CP0_CAUSE;
    wr_epc     = do_mtc0 && cp0_sel_q == 3'd0 && cp0_addr_q == CP0_EPC;
    wr_count   = do_mtc0 && cp0_sel_q == 3'd0 && cp0_addr_q == CP0_COUNT;
    wr_compare = do_mtc0 && cp0_sel_q == 3'd0 && cp0_addr_q == CP0_COMPARE;
  end

  always_comb begin
    status_val = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    cause_val  = {cause_bd, ti, 14'd0, hw_q[5] | ti, hw_q[4:0], ip_sw, 1'b0, exc_code, 2'd0};
    cp0_rdata  = 32'd0;
    if (cp0_sel_q == 3'd0) begin
      case (cp0_addr_q)
        CP0_BADVADDR: cp0_rdata = badvaddr;
        CP0_COUNT:    cp0_rdata = count;
        CP0_COMPARE:  cp0_rdata = compare;
        CP0_STATUS:   cp0_rdata = status_val;
        CP0_CAUSE:    cp0_rdata = cause_val;
        CP0_EPC:      cp0_rdata = epc;
        default:      cp0_rdata = 32'd0;
      endcase
    end
  end

  // CP0 state: exception/ERET side effects, MTC0 writes, timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      im       <= 8'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      cause_bd <= 1'b0;
      ti       <= 1'b0;
      ip_sw    <= 2'd0;
      hw_q     <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      tick     <= '0;
    end else begin
      hw_q <= hw_int;
      if (take_exc) begin
        exl      <= 1'b1;
        exc_code <= code_q;
        // A nested exception keeps the original return point.
        if (!exl) begin
          cause_bd <= bd_q;
          epc      <= bd_q ? pc_q - 32'd4 : pc_q;
        end
        if (af_q) badvaddr <= badvaddr_q;
      end else if (take_eret) begin
        exl <= 1'b0;
      end
      if (wr_status) begin
        im  <= result_q[15:8];
        exl <= result_q[1];
        ie  <= result_q[0];
      end
      if (wr_cause)   ip_sw   <= result_q[9:8];
      if (wr_epc)     epc     <= result_q;
      if (wr_compare) compare <= result_q;
      if (wr_count) begin
        count <= result_q;
        tick  <= '0;
      end else if (tick == TICK_LAST) begin
        count <= count + 32'd1;
        tick  <= '0;
      end else begin
        tick <= tick + TICK_W'(1);
      end
      // A Compare write wins over a same-cycle match.
      if (wr_compare)            ti <= 1'b0;
      else if (count == compare) ti <= 1'b1;
    end
  end

  always_comb begin
    wb_allow_in  = 1'b1;
    rf_we        = {4{retire & rf_we_q & ~exc_q & ~eret_q}} & strobe_q;
    rf_waddr     = rf_addr_q;
    rf_wdata     = mfc0_q ? cp0_rdata : result_q;
    flush        = take_exc | take_eret;
    flush_target = take_eret ? epc : EXC_ENTRY;
    int_pending  = ie & ~exl & (|(cause_val[15:8] & im));
    wb_fwd_valid = retire & rf_we_q;
    wb_fwd_addr  = rf_addr_q;
    wb_fwd_data  = rf_wdata;
    debug_pc     = pc_q;
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: expected retire results are queued at
// issue time and popped when the instruction is in the commit cycle.
module tb_wb_commit_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic [3:0]  strobe;
    logic [4:0]  cp0;
    logic [2:0]  sel;
    logic        mfc0;
    logic        mtc0;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
    logic        eret;
    logic        af;
    logic [31:0] bva;
  } ins_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] target;
    logic        fwd;
    logic [31:0] pc;
  } exp_t;

  logic        clock, reset;
  logic        wb_allow_in, in_valid;
  logic [31:0] in_pc, in_result, in_badvaddr;
  logic [4:0]  in_rf_addr, in_cp0_addr, in_exc_code;
  logic        in_rf_we, in_mfc0, in_mtc0, in_exc_valid, in_bd, in_eret, in_addr_fault;
  logic [3:0]  in_rf_strobe;
  logic [2:0]  in_cp0_sel;
  logic [5:0]  hw_int;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr, wb_fwd_addr;
  logic [31:0] rf_wdata, flush_target, wb_fwd_data, debug_pc;
  logic        flush, int_pending, wb_fwd_valid;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  wb_commit_stage #(.EXC_ENTRY(32'hBFC0_0380), .COUNT_DIV(2)) dut (
    .clock(clock), .reset(reset), .wb_allow_in(wb_allow_in), .in_valid(in_valid),
    .in_pc(in_pc), .in_result(in_result), .in_rf_addr(in_rf_addr), .in_rf_we(in_rf_we),
    .in_rf_strobe(in_rf_strobe), .in_cp0_addr(in_cp0_addr), .in_cp0_sel(in_cp0_sel),
    .in_mfc0(in_mfc0), .in_mtc0(in_mtc0), .in_exc_valid(in_exc_valid),
    .in_exc_code(in_exc_code), .in_bd(in_bd), .in_eret(in_eret),
    .in_addr_fault(in_addr_fault), .in_badvaddr(in_badvaddr), .hw_int(hw_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush),
    .flush_target(flush_target), .int_pending(int_pending), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data), .debug_pc(debug_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] res, input logic [3:0] strobe);
    ins_t i = '0;
    i.pc = pc; i.rd = rd; i.result = res; i.we = 1'b1; i.strobe = strobe;
    return i;
  endfunction

  function automatic ins_t mfc0_i(input logic [31:0] pc, input logic [4:0] rd,
                                  input logic [4:0] cp0, input logic [2:0] sel);
    ins_t i = '0;
    i.pc = pc; i.rd = rd; i.we = 1'b1; i.strobe = 4'hF; i.mfc0 = 1'b1;
    i.cp0 = cp0; i.sel = sel; i.result = 32'h1111_2222;
    return i;
  endfunction

  function automatic ins_t mtc0_i(input logic [31:0] pc, input logic [4:0] cp0,
                                  input logic [31:0] data);
    ins_t i = '0;
    i.pc = pc; i.mtc0 = 1'b1; i.cp0 = cp0; i.result = data;
    return i;
  endfunction

  function automatic ins_t exc_i(input logic [31:0] pc, input logic [4:0] code,
                                 input logic bd, input logic af, input logic [31:0] bva);
    ins_t i = '0;
    i.pc = pc; i.exc = 1'b1; i.code = code; i.bd = bd; i.af = af; i.bva = bva;
    i.we = 1'b1; i.rd = 5'd7; i.strobe = 4'hF; i.result = 32'hDEAD_BEEF;
    return i;
  endfunction

  function automatic ins_t eret_i(input logic [31:0] pc);
    ins_t i = '0;
    i.pc = pc; i.eret = 1'b1; i.we = 1'b1; i.rd = 5'd9; i.strobe = 4'hF;
    i.result = 32'h0BAD_F00D;
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic v);
    in_valid      = v;
    in_pc         = i.pc;
    in_result     = i.result;
    in_rf_addr    = i.rd;
    in_rf_we      = i.we;
    in_rf_strobe  = i.strobe;
    in_cp0_addr   = i.cp0;
    in_cp0_sel    = i.sel;
    in_mfc0       = i.mfc0;
    in_mtc0       = i.mtc0;
    in_exc_valid  = i.exc;
    in_exc_code   = i.code;
    in_bd         = i.bd;
    in_eret       = i.eret;
    in_addr_fault = i.af;
    in_badvaddr   = i.bva;
  endtask

  // Issue at a negedge; the instruction is in its commit cycle one negedge later.
  task automatic issue(input string tag, input ins_t i, input logic [3:0] x_we,
                       input logic [31:0] x_wdata, input logic x_flush,
                       input logic [31:0] x_target);
    exp_t e, o;
    drive(i, 1'b1);
    e.we = x_we; e.waddr = i.rd; e.wdata = x_wdata; e.flush = x_flush;
    e.target = x_target; e.fwd = i.we; e.pc = i.pc;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    o = exp_q.pop_front();
    check({tag, ".rf_we"}, 32'(rf_we), 32'(o.we));
    check({tag, ".waddr"}, 32'(rf_waddr), 32'(o.waddr));
    check({tag, ".wdata"}, rf_wdata, o.wdata);
    check({tag, ".flush"}, 32'(flush), 32'(o.flush));
    if (o.flush) check({tag, ".target"}, flush_target, o.target);
    check({tag, ".fwd_valid"}, 32'(wb_fwd_valid), 32'(o.fwd));
    check({tag, ".debug_pc"}, debug_pc, o.pc);
  endtask

  task automatic settle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic mid_reset(input string tag, input ins_t i);
    drive(i, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    check({tag, ".flush"}, 32'(flush), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hw_int = 6'd0;
    drive('0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    settle();

    check("reset.allow_in", 32'(wb_allow_in), 32'd1);
    check("reset.rf_we", 32'(rf_we), 32'd0);
    check("reset.flush", 32'(flush), 32'd0);
    check("reset.fwd_valid", 32'(wb_fwd_valid), 32'd0);
    check("reset.int_pending", 32'(int_pending), 32'd0);

    issue("cmp_far", mtc0_i(32'hBFC0_0000, 5'd11, 32'hFFFF_FFFF), 4'h0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    issue("addu", alu(32'hBFC0_0010, 5'd3, 32'h0000_1234, 4'hF), 4'hF, 32'h0000_1234, 1'b0, 32'd0);
    issue("lwl", alu(32'hBFC0_0014, 5'd5, 32'hAABB_CCDD, 4'b1100), 4'b1100, 32'hAABB_CCDD, 1'b0, 32'd0);
    begin
      ins_t i = alu(32'hBFC0_0018, 5'd5, 32'hAABB_CCDD, 4'b1100);
      i.exc = 1'b1; i.code = 5'd4;
      issue("lwl_exc", i, 4'h0, 32'hAABB_CCDD, 1'b1, 32'hBFC0_0380);
    end
    issue("st_exl", mfc0_i(32'hBFC0_0380, 5'd2, 5'd12, 3'd0), 4'hF, 32'h0040_0002, 1'b0, 32'd0);
    issue("st_clr", mtc0_i(32'hBFC0_0384, 5'd12, 32'h0000_0000), 4'h0, 32'h0000_0000, 1'b0, 32'd0);
    issue("st_bev", mfc0_i(32'hBFC0_0388, 5'd2, 5'd12, 3'd0), 4'hF, 32'h0040_0000, 1'b0, 32'd0);

    issue("syscall_bd", exc_i(32'hBFC0_0104, 5'd8, 1'b1, 1'b0, 32'd0), 4'h0, 32'hDEAD_BEEF, 1'b1, 32'hBFC0_0380);
    issue("epc_bd", mfc0_i(32'hBFC0_0380, 5'd2, 5'd14, 3'd0), 4'hF, 32'hBFC0_0100, 1'b0, 32'd0);
    issue("cause_bd", mfc0_i(32'hBFC0_0384, 5'd2, 5'd13, 3'd0), 4'hF, 32'h8000_0020, 1'b0, 32'd0);
    issue("st_exl2", mfc0_i(32'hBFC0_0388, 5'd2, 5'd12, 3'd0), 4'hF, 32'h0040_0002, 1'b0, 32'd0);
    issue("nested_exc", exc_i(32'hBFC0_0500, 5'd10, 1'b0, 1'b0, 32'd0), 4'h0, 32'hDEAD_BEEF, 1'b1, 32'hBFC0_0380);
    issue("epc_held", mfc0_i(32'hBFC0_0380, 5'd2, 5'd14, 3'd0), 4'hF, 32'hBFC0_0100, 1'b0, 32'd0);
    issue("cause_nest", mfc0_i(32'hBFC0_0384, 5'd2, 5'd13, 3'd0), 4'hF, 32'h8000_0028, 1'b0, 32'd0);

    issue("mtc0_epc", mtc0_i(32'hBFC0_0388, 5'd14, 32'hBFC0_0200), 4'h0, 32'hBFC0_0200, 1'b0, 32'd0);
    issue("eret", eret_i(32'hBFC0_038C), 4'h0, 32'h0BAD_F00D, 1'b1, 32'hBFC0_0200);
    issue("st_eret", mfc0_i(32'hBFC0_0200, 5'd2, 5'd12, 3'd0), 4'hF, 32'h0040_0000, 1'b0, 32'd0);

    issue("misalign", exc_i(32'hBFC0_0600, 5'd4, 1'b0, 1'b1, 32'h8000_0003), 4'h0, 32'hDEAD_BEEF, 1'b1, 32'hBFC0_0380);
    issue("bva_rd", mfc0_i(32'hBFC0_0380, 5'd4, 5'd8, 3'd0), 4'hF, 32'h8000_0003, 1'b0, 32'd0);
    issue("bva_wr", mtc0_i(32'hBFC0_0384, 5'd8, 32'h0000_0000), 4'h0, 32'h0000_0000, 1'b0, 32'd0);
    issue("bva_ro", mfc0_i(32'hBFC0_0388, 5'd4, 5'd8, 3'd0), 4'hF, 32'h8000_0003, 1'b0, 32'd0);
    issue("epc_mis", mfc0_i(32'hBFC0_038C, 5'd4, 5'd14, 3'd0), 4'hF, 32'hBFC0_0600, 1'b0, 32'd0);
    issue("sel1", mfc0_i(32'hBFC0_0390, 5'd4, 5'd14, 3'd1), 4'hF, 32'h0000_0000, 1'b0, 32'd0);
    issue("unimpl", mfc0_i(32'hBFC0_0394, 5'd4, 5'd15, 3'd0), 4'hF, 32'h0000_0000, 1'b0, 32'd0);

    issue("cmp5", mtc0_i(32'hBFC0_0700, 5'd11, 32'd5), 4'h0, 32'd5, 1'b0, 32'd0);
    issue("cnt0", mtc0_i(32'hBFC0_0704, 5'd9, 32'd0), 4'h0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 16; k++)
      issue($sformatf("ti_poll%0d", k), mfc0_i(32'hBFC0_0708, 5'd2, 5'd13, 3'd0), 4'hF,
            (k >= 11) ? 32'h4000_8010 : 32'h0000_0010, 1'b0, 32'd0);
    issue("st_8001", mtc0_i(32'hBFC0_0710, 5'd12, 32'h0000_8001), 4'h0, 32'h0000_8001, 1'b0, 32'd0);
    settle();
    check("int_pend_ti", 32'(int_pending), 32'd1);
    issue("cmp100", mtc0_i(32'hBFC0_0714, 5'd11, 32'd100), 4'h0, 32'd100, 1'b0, 32'd0);
    issue("ti_clr", mfc0_i(32'hBFC0_0718, 5'd2, 5'd13, 3'd0), 4'hF, 32'h0000_0010, 1'b0, 32'd0);
    check("int_pend_clr", 32'(int_pending), 32'd0);

    issue("cnt50", mtc0_i(32'hBFC0_0720, 5'd9, 32'd50), 4'h0, 32'd50, 1'b0, 32'd0);
    issue("cmp50a", mtc0_i(32'hBFC0_0724, 5'd11, 32'd50), 4'h0, 32'd50, 1'b0, 32'd0);
    issue("cmp50b", mtc0_i(32'hBFC0_0728, 5'd11, 32'd50), 4'h0, 32'd50, 1'b0, 32'd0);
    issue("ti_tie", mfc0_i(32'hBFC0_072C, 5'd2, 5'd13, 3'd0), 4'hF, 32'h0000_0010, 1'b0, 32'd0);
    check("int_pend_tie", 32'(int_pending), 32'd0);

    hw_int = 6'b000001;
    issue("st_0401", mtc0_i(32'hBFC0_0730, 5'd12, 32'h0000_0401), 4'h0, 32'h0000_0401, 1'b0, 32'd0);
    issue("cause_hw", mfc0_i(32'hBFC0_0734, 5'd2, 5'd13, 3'd0), 4'hF, 32'h0000_0410, 1'b0, 32'd0);
    check("int_pend_hw", 32'(int_pending), 32'd1);
    issue("cause_wr", mtc0_i(32'hBFC0_0738, 5'd13, 32'hFFFF_FFFF), 4'h0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    issue("cause_sw", mfc0_i(32'hBFC0_073C, 5'd2, 5'd13, 3'd0), 4'hF, 32'h0000_0710, 1'b0, 32'd0);
    hw_int = 6'd0;

    mid_reset("rst_alu", alu(32'hBFC0_0800, 5'd6, 32'h0000_0055, 4'hF));
    mid_reset("rst_exc", exc_i(32'hBFC0_0804, 5'd8, 1'b0, 1'b1, 32'h1234_5678));
    issue("post_st", mfc0_i(32'hBFC0_0000, 5'd2, 5'd12, 3'd0), 4'hF, 32'h0040_0000, 1'b0, 32'd0);
    issue("post_epc", mfc0_i(32'hBFC0_0004, 5'd2, 5'd14, 3'd0), 4'hF, 32'h0000_0000, 1'b0, 32'd0);
    issue("post_bva", mfc0_i(32'hBFC0_0008, 5'd2, 5'd8, 3'd0), 4'hF, 32'h0000_0000, 1'b0, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
